age_issue_select: RTL

- Parametrised, age-ordered issue selector for one reservation-station bank. Next generation of the per-category issue allocator.
- Each cycle, picks up to NUM_PORTS ready entries, oldest first, and drives combinational clear indices back to the RS.
- Registers the selected payloads into per-port issue registers with a valid/ready handshake to the FUs.
- One instance is placed per RS bank (ALU, MULT, BRANCH, MEM) in the issue stage.

---
 rtl/age_issue_select_pkg.sv | 8 +
 rtl/age_issue_select_age_matrix.sv | 65 ++++++
 rtl/age_issue_select.sv | 112 +++++++++++
 3 files changed

// File: rtl/age_issue_select_pkg.sv
// rtl/age_issue_select_pkg.sv - default bank geometry for the age-ordered issue selector
package age_issue_select_pkg;

    localparam int DEFAULT_NUM_ENTRIES = 8;
    localparam int DEFAULT_NUM_PORTS   = 2;
    localparam int DEFAULT_PAYLOAD_W   = 64;

endpackage

// File: rtl/age_issue_select_age_matrix.sv
// rtl/age_issue_select_age_matrix.sv - relative-age matrix with oldest-first pick chain
module age_matrix
    import age_issue_select_pkg::*;
#(
    parameter int NUM_ENTRIES = DEFAULT_NUM_ENTRIES,
    parameter int NUM_PICKS   = DEFAULT_NUM_PORTS
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_ENTRIES-1:0]           alloc,
    input  logic [NUM_ENTRIES-1:0]           req_mask,
    output logic [NUM_PICKS*NUM_ENTRIES-1:0] picks
);

    // older[i][j] = 1 : entry i was allocated before entry j
    logic [NUM_ENTRIES-1:0] older [NUM_ENTRIES];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (alloc[i]) begin
                        older[i][j] <= alloc[j] && (i < j);
                    end else if (alloc[j]) begin
                        older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    // Pick p is the oldest entry left after removing picks 0..p-1; the
    // lowest index breaks any tie so each pick stays one-hot.
    always_comb begin
        logic [NUM_ENTRIES-1:0] remaining;
        logic                   found;
        logic                   blocked;
        picks     = '0;
        remaining = req_mask;
        found     = 1'b0;
        blocked   = 1'b0;
        for (int p = 0; p < NUM_PICKS; p++) begin
            found = 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                blocked = 1'b0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (remaining[j] && older[j][i]) begin
                        blocked = 1'b1;
                    end
                end
                if (remaining[i] && !blocked && !found) begin
                    picks[p*NUM_ENTRIES + i] = 1'b1;
                    found = 1'b1;
                end
            end
            remaining = remaining & ~picks[p*NUM_ENTRIES +: NUM_ENTRIES];
        end
    end

endmodule

// File: rtl/age_issue_select.sv
// rtl/age_issue_select.sv - oldest-first multi-port issue select with per-port issue registers
module age_issue_select
    import age_issue_select_pkg::*;
#(
    parameter int NUM_ENTRIES = DEFAULT_NUM_ENTRIES,
    parameter int NUM_PORTS   = DEFAULT_NUM_PORTS,
    parameter int PAYLOAD_W   = DEFAULT_PAYLOAD_W,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_ENTRIES-1:0]           alloc,
    input  logic [NUM_ENTRIES-1:0]           req,
    input  logic [NUM_ENTRIES*PAYLOAD_W-1:0] entry_payload,
    input  logic [NUM_PORTS-1:0]             port_avail,
    input  logic [NUM_PORTS-1:0]             out_ready,
    output logic [NUM_PORTS-1:0]             clear_valid,
    output logic [NUM_PORTS*IDX_W-1:0]       clear_idx,
    output logic [NUM_PORTS-1:0]             out_valid,
    output logic [NUM_PORTS*PAYLOAD_W-1:0]   out_payload,
    output logic [NUM_PORTS*IDX_W-1:0]       out_idx,
    output logic [NUM_PORTS-1:0]             cdb_req
);

    logic [NUM_ENTRIES-1:0]           eligible;
    logic [NUM_PORTS*NUM_ENTRIES-1:0] picks;
    logic [NUM_PORTS-1:0]             valid_next;
    logic [NUM_PORTS*PAYLOAD_W-1:0]   payload_next;
    logic [NUM_PORTS*IDX_W-1:0]       idx_next;

    // An entry written this cycle has stale sources; it waits a cycle.
    assign eligible = req & ~alloc;

    age_matrix #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .NUM_PICKS  (NUM_PORTS)
    ) u_age_matrix (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .alloc   (alloc),
        .req_mask(eligible),
        .picks   (picks)
    );

    // Free port k consumes pick number "free ports below k", so a stalled
    // or gated port never shifts the oldest entries past the later ports.
    always_comb begin
        logic [NUM_ENTRIES-1:0] onehot;
        logic [IDX_W-1:0]       sel_idx;
        logic [PAYLOAD_W-1:0]   sel_payload;
        logic                   port_free;
        int                     rank;
        clear_valid  = '0;
        clear_idx    = '0;
        valid_next   = '0;
        payload_next = out_payload;
        idx_next     = out_idx;
        onehot       = '0;
        sel_idx      = '0;
        sel_payload  = '0;
        port_free    = 1'b0;
        rank         = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            onehot      = '0;
            sel_idx     = '0;
            sel_payload = '0;
            port_free   = port_avail[k] && (!out_valid[k] || out_ready[k]);
            if (port_free && !flush && !reset) begin
                for (int r = 0; r < NUM_PORTS; r++) begin
                    if (r == rank) begin
                        onehot = picks[r*NUM_ENTRIES +: NUM_ENTRIES];
                    end
                end
                rank = rank + 1;
            end
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (onehot[i]) begin
                    sel_idx     = IDX_W'(i);
                    sel_payload = entry_payload[i*PAYLOAD_W +: PAYLOAD_W];
                end
            end
            valid_next[k] = out_valid[k] && !out_ready[k];
            if (|onehot) begin
                clear_valid[k]                      = 1'b1;
                clear_idx[k*IDX_W +: IDX_W]         = sel_idx;
                valid_next[k]                       = 1'b1;
                idx_next[k*IDX_W +: IDX_W]          = sel_idx;
                payload_next[k*PAYLOAD_W +: PAYLOAD_W] = sel_payload;
            end
            if (flush || reset) begin
                valid_next[k] = 1'b0;
            end
        end
    end

    assign cdb_req = valid_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= '0;
            out_payload <= '0;
            out_idx     <= '0;
        end else begin
            out_valid   <= valid_next;
            out_payload <= payload_next;
            out_idx     <= idx_next;
        end
    end

endmodule
